reg_dump_tx: RTL
================

REG_DUMP_TX -- requirements
Module: reg_dump_tx

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of register-file entries walked per dump (2..32).
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request a dump; sampled only in IDLE.
REQ-006 SHALL have port rf_raddr, output, 5, register-file read address.
REQ-007 SHALL have port rf_rdata, input, DATA_W, register-file read data, combinational from rf_raddr.
REQ-008 SHALL have port dump_valid, output, 1, beat present on dump_idx/dump_data.
REQ-009 SHALL have port dump_ready, input, 1, sink accepts a beat when high with dump_valid.
REQ-010 SHALL have port dump_idx, output, 5, register index of the current beat.
REQ-011 SHALL have port dump_data, output, DATA_W, register value of the current beat.
REQ-012 SHALL have port dump_csum, output, 1, current beat is the checksum beat.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle pulse after the final beat is accepted.

Function
REQ-015 SHALL implement the states IDLE, LOAD, SEND, CSUM and DONE.
REQ-016 IDLE with start=1 SHALL clear the index and accumulator and move to LOAD; start=0 SHALL keep IDLE.
REQ-017 LOAD SHALL drive rf_raddr=index, register rf_rdata into dump_data, XOR it into the accumulator, and move to SEND.
REQ-018 SEND SHALL hold dump_valid=1, with dump_idx=index and dump_data stable until the cycle dump_valid and dump_ready are both high.
REQ-019 On acceptance in SEND with index<NUM_REGS-1, the block SHALL increment the index and move to LOAD.
REQ-020 On acceptance in SEND with index=NUM_REGS-1, the block SHALL move to CSUM (macro defined) or DONE (macro undefined).
REQ-021 CSUM SHALL present dump_valid=1, dump_csum=1, dump_idx=NUM_REGS-1 and dump_data=accumulator until accepted, then move to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-023 Throughput SHALL be one beat per 2 cycles with dump_ready held high; the first dump_valid SHALL rise 2 cycles after start is sampled.
REQ-024 start SHALL be ignored while busy=1, with no restart or queuing.
REQ-025 dump_valid SHALL never drop without acceptance, and dump_idx/dump_data SHALL not change while valid is pending.
REQ-026 rf_raddr SHALL equal the index in all states (0 in IDLE).
REQ-027 The index SHALL never wrap past NUM_REGS-1.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, index=0, accumulator=0, rf_raddr=0, dump_valid=0, dump_idx=0, dump_data=0, dump_csum=0, busy=0, done=0.
REQ-029 Reset mid-dump SHALL abort it with no done pulse; a later start SHALL begin again at register 0.

Configuration
REQ-030 Macro REG_DUMP_TX_CHECKSUM_EN defined SHALL include the accumulator and CSUM state, giving NUM_REGS+1 beats per dump.
REQ-031 Macro REG_DUMP_TX_CHECKSUM_EN undefined SHALL remove the accumulator and CSUM, tie dump_csum to 0, and give NUM_REGS beats per dump.

Structure
REQ-032 State encodings and the REG_ADDR_W=5 constant SHALL live in the shared cpu_defs package.
REQ-033 The block SHALL be a single module with no sub-module; the FSM and datapath are fused.

Verification
REQ-034 Preload r0=0, ri=i, r5=0xDEADBEEF, ready=1, pulse start -> 32 beats with idx 0..31 and matching data, every 2 cycles, done pulses 1 cycle after beat 31.
REQ-035 Same preload with CHECKSUM_EN -> a 33rd beat with dump_csum=1 and dump_data=0xDEADBEEA, then done.
REQ-036 Hold ready low for 5 cycles on beat 7 -> valid stays high with idx=7 and data=7 unchanged; beat 8 follows only after acceptance.
REQ-037 Pulse start again during beat 10 -> ignored; exactly one dump and one done pulse.
REQ-038 Assert rst at beat 12 -> all outputs 0 immediately and no done; next start -> dump restarts at idx 0.
REQ-039 NUM_REGS=2, ready=1 -> 2 beats (idx 0,1), done, return to IDLE with busy=0.

Source files
------------

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU constants and reg_dump_tx state encodings
package cpu_defs;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/reg_dump_tx.sv
// rtl/reg_dump_tx.sv - register-file dump streamer, optional XOR checksum beat (REG_DUMP_TX_CHECKSUM_EN)
module reg_dump_tx
    import cpu_defs::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [REG_ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0]     rf_rdata,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [REG_ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  dump_csum,
    output logic                  busy,
    output logic                  done
);

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

    dump_state_t           state;
    logic [REG_ADDR_W-1:0] index;

    // The register file is addressed straight from the walk index.
    assign rf_raddr = index;

`ifdef REG_DUMP_TX_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
    logic              csum_q;

    assign dump_csum = csum_q;

    // Dump FSM with XOR accumulator and trailing checksum beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            index      <= '0;
            acc        <= '0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            csum_q     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        index <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    dump_data  <= rf_rdata;
                    dump_idx   <= index;
                    acc        <= acc ^ rf_rdata;
                    dump_valid <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (index == LAST_IDX) begin
                            state <= ST_CSUM;
                        end else begin
                            index <= index + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_CSUM: begin
                    // First cycle stages the checksum so beats stay two cycles apart.
                    if (!dump_valid) begin
                        dump_valid <= 1'b1;
                        csum_q     <= 1'b1;
                        dump_idx   <= LAST_IDX;
                        dump_data  <= acc;
                    end else if (dump_ready) begin
                        dump_valid <= 1'b0;
                        csum_q     <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    index <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
`else
    assign dump_csum = 1'b0;

    // Dump FSM walking the register file, no checksum beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            index      <= '0;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        index <= '0;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    dump_data  <= rf_rdata;
                    dump_idx   <= index;
                    dump_valid <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (index == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            index <= index + 1'b1;
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    index <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
`endif

endmodule
